// File: rtl/alu_sequencer.sv
// Byte-serial sequencer driving the 8-bit ALU for multi-byte ADD, SUB and SHR.
// Every output is registered from the next-state decode, so a step's strobes appear in the cycle its state is entered.
module alu_sequencer #(
    parameter int AW     = 8,
    parameter int LW     = 4,
    parameter int MAXLEN = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [LW-1:0] len,
    input  logic [AW-1:0] src_a,
    input  logic [AW-1:0] src_b,
    input  logic [AW-1:0] dst,
    input  logic [7:0]    dbus,
    input  logic          flagCarry,
    input  logic          flagShift,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          result_zero,
    output logic          carry_out,
    output logic [AW-1:0] addr,
    output logic          assertBarM,
    output logic          memWrite,
    output logic          loadA,
    output logic          loadB,
    output logic          clearA,
    output logic          doSubtract,
    output logic          doCarryIn,
    output logic          assertBarE,
    output logic          assertBarS,
    output logic          triggerC,
    output logic          triggerS
);

    typedef enum logic [3:0] {
        IDLE, LDA, LDB, EXEC, CARRY, CLRA, CLRS, SHLD, SHIFT, SFLAG, DONE
    } state_t;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHR = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    state_t        state, state_nx;
    logic [LW-1:0] idx, idx_nx, len_q, len_nx;
    logic [1:0]    op_q, op_nx;
    logic [AW-1:0] sa_q, sa_nx, sb_q, sb_nx, dst_q, dst_nx;
    logic          zero_nx, err_nx, carry_nx, last_byte, bad_cmd;
    logic [AW-1:0] off_nx, addr_nx;
    logic          busy_nx, done_nx, bar_m_nx, bar_e_nx, bar_s_nx, mem_write_nx;
    logic          load_a_nx, load_b_nx, clear_a_nx, sub_nx, cin_nx, trig_c_nx, trig_s_nx;

    assign last_byte = (idx == len_q - LW'(1));
    assign bad_cmd   = (op == OP_BAD) || (len == '0) || (len > LW'(MAXLEN)) ||
                       ((op == OP_SUB) && (len != LW'(1)));

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        op_nx    = op_q;
        len_nx   = len_q;
        sa_nx    = sa_q;
        sb_nx    = sb_q;
        dst_nx   = dst_q;
        zero_nx  = result_zero;
        err_nx   = 1'b0;
        carry_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nx   = op;
                    len_nx  = len;
                    sa_nx   = src_a;
                    sb_nx   = src_b;
                    dst_nx  = dst;
                    zero_nx = 1'b1;
                    idx_nx  = '0;
                    if (bad_cmd) begin
                        state_nx = DONE;
                        err_nx   = 1'b1;
                    end else if (op == OP_SHR) begin
                        state_nx = CLRA;
                    end else begin
                        state_nx = LDA;
                    end
                end
            end
            LDA:   state_nx = LDB;
            LDB:   state_nx = EXEC;
            EXEC: begin
                state_nx = CARRY;
                if (dbus != 8'h00) zero_nx = 1'b0;
            end
            CARRY: begin
                if (last_byte) begin
                    state_nx = DONE;
                    carry_nx = flagCarry;
                end else begin
                    state_nx = LDA;
                    idx_nx   = idx + LW'(1);
                end
            end
            CLRA:  state_nx = CLRS;
            CLRS: begin
                state_nx = SHLD;
                idx_nx   = '0;
            end
            SHLD:  state_nx = SHIFT;
            SHIFT: begin
                state_nx = SFLAG;
                if (dbus != 8'h00) zero_nx = 1'b0;
            end
            SFLAG: begin
                if (last_byte) begin
                    state_nx = DONE;
                    carry_nx = flagShift;
                end else begin
                    state_nx = SHLD;
                    idx_nx   = idx + LW'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Shifts walk from the most-significant byte down, so their offset counts backwards from len-1.
    always_comb begin
        off_nx       = AW'(idx_nx);
        addr_nx      = '0;
        busy_nx      = (state_nx != IDLE);
        done_nx      = 1'b0;
        bar_m_nx     = 1'b1;
        bar_e_nx     = 1'b1;
        bar_s_nx     = 1'b1;
        mem_write_nx = 1'b0;
        load_a_nx    = 1'b0;
        load_b_nx    = 1'b0;
        clear_a_nx   = 1'b0;
        sub_nx       = 1'b0;
        cin_nx       = 1'b0;
        trig_c_nx    = 1'b0;
        trig_s_nx    = 1'b0;
        if ((state_nx == SHLD) || (state_nx == SHIFT))
            off_nx = AW'(len_nx) - AW'(1) - AW'(idx_nx);
        case (state_nx)
            LDA: begin
                addr_nx   = sa_nx + off_nx;
                bar_m_nx  = 1'b0;
                load_a_nx = 1'b1;
            end
            LDB: begin
                addr_nx   = sb_nx + off_nx;
                bar_m_nx  = 1'b0;
                load_b_nx = 1'b1;
            end
            EXEC: begin
                addr_nx      = dst_nx + off_nx;
                bar_e_nx     = 1'b0;
                mem_write_nx = 1'b1;
                cin_nx       = (idx_nx != '0);
                sub_nx       = (op_nx == OP_SUB);
            end
            CARRY: trig_c_nx = 1'b1;
            CLRA:  clear_a_nx = 1'b1;
            CLRS:  trig_s_nx = 1'b1;
            SHLD: begin
                addr_nx   = sa_nx + off_nx;
                bar_m_nx  = 1'b0;
                load_a_nx = 1'b1;
            end
            SHIFT: begin
                addr_nx      = dst_nx + off_nx;
                bar_s_nx     = 1'b0;
                mem_write_nx = 1'b1;
            end
            SFLAG: trig_s_nx = 1'b1;
            DONE:  done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            op_q        <= '0;
            len_q       <= '0;
            sa_q        <= '0;
            sb_q        <= '0;
            dst_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            result_zero <= 1'b1;
            carry_out   <= 1'b0;
            addr        <= '0;
            assertBarM  <= 1'b1;
            assertBarE  <= 1'b1;
            assertBarS  <= 1'b1;
            memWrite    <= 1'b0;
            loadA       <= 1'b0;
            loadB       <= 1'b0;
            clearA      <= 1'b0;
            doSubtract  <= 1'b0;
            doCarryIn   <= 1'b0;
            triggerC    <= 1'b0;
            triggerS    <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            op_q        <= op_nx;
            len_q       <= len_nx;
            sa_q        <= sa_nx;
            sb_q        <= sb_nx;
            dst_q       <= dst_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
            result_zero <= zero_nx;
            carry_out   <= carry_nx;
            addr        <= addr_nx;
            assertBarM  <= bar_m_nx;
            assertBarE  <= bar_e_nx;
            assertBarS  <= bar_s_nx;
            memWrite    <= mem_write_nx;
            loadA       <= load_a_nx;
            loadB       <= load_b_nx;
            clearA      <= clear_a_nx;
            doSubtract  <= sub_nx;
            doCarryIn   <= cin_nx;
            triggerC    <= trig_c_nx;
            triggerS    <= trig_s_nx;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a small memory, A/B register and ALU model around it.
module tb_alu_sequencer;

    logic       clk, reset, start;
    logic [1:0] op_i;
    logic [3:0] len_i;
    logic [7:0] src_a_i, src_b_i, dst_i, dbus;
    logic       flagCarry, flagShift;
    logic       busy, done, err, result_zero, carry_out;
    logic [7:0] addr;
    logic       assertBarM, memWrite, loadA, loadB, clearA, doSubtract, doCarryIn;
    logic       assertBarE, assertBarS, triggerC, triggerS;

    logic [7:0] mem [256];
    logic [7:0] reg_a, reg_b;
    logic [8:0] alu_sum;
    logic       alu_cin, pend_carry, prev_trig_c, prev_trig_s;
    logic [7:0] read_log [$];
    logic [7:0] write_log [$];
    logic       cin_log [$];
    int         n_vec, n_fail;
    int         lat;
    logic       r_err, r_zero, r_carry;

    alu_sequencer #(.AW(8), .LW(4), .MAXLEN(8)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op_i), .len(len_i),
        .src_a(src_a_i), .src_b(src_b_i), .dst(dst_i), .dbus(dbus),
        .flagCarry(flagCarry), .flagShift(flagShift),
        .busy(busy), .done(done), .err(err), .result_zero(result_zero),
        .carry_out(carry_out), .addr(addr), .assertBarM(assertBarM),
        .memWrite(memWrite), .loadA(loadA), .loadB(loadB), .clearA(clearA),
        .doSubtract(doSubtract), .doCarryIn(doCarryIn), .assertBarE(assertBarE),
        .assertBarS(assertBarS), .triggerC(triggerC), .triggerS(triggerS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: subtract is A + ~B + 1; add threads the captured carry when doCarryIn is set.
    always_comb begin
        alu_cin = doSubtract ? 1'b1 : (doCarryIn & flagCarry);
        alu_sum = {1'b0, reg_a} + {1'b0, (doSubtract ? ~reg_b : reg_b)} + {8'h00, alu_cin};
        dbus    = 8'h00;
        if (!assertBarM)      dbus = mem[addr];
        else if (!assertBarE) dbus = alu_sum[7:0];
        else if (!assertBarS) dbus = {flagShift, reg_a[7:1]};
    end

    always @(posedge clk) begin
        if (loadA)       reg_a <= dbus;
        if (clearA)      reg_a <= 8'h00;
        if (loadB)       reg_b <= dbus;
        if (memWrite)    mem[addr] <= dbus;
        if (!assertBarE) pend_carry <= alu_sum[8];
    end

    // Flags capture on trigger rising edges, sampled mid-cycle to stay clear of the clock edge.
    always @(negedge clk) begin
        if (triggerC && !prev_trig_c) flagCarry <= pend_carry;
        if (triggerS && !prev_trig_s) flagShift <= reg_a[0];
        prev_trig_c <= triggerC;
        prev_trig_s <= triggerS;
        if (!assertBarM) read_log.push_back(addr);
        if (memWrite)    write_log.push_back(addr);
        if (!assertBarE) cin_log.push_back(doCarryIn);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command, scrambles the command inputs after accept, and waits for done.
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] l, input logic [7:0] sa,
                                 input logic [7:0] sb, input logic [7:0] d);
        @(negedge clk);
        read_log.delete();
        write_log.delete();
        cin_log.delete();
        op_i = o; len_i = l; src_a_i = sa; src_b_i = sb; dst_i = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op_i = 2'b11; len_i = 4'd0; src_a_i = 8'h33; src_b_i = 8'h44; dst_i = 8'h55;
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                r_err = err; r_zero = result_zero; r_carry = carry_out;
                break;
            end
        end
    endtask

    initial begin
        n_vec = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0;
        op_i = 2'b00; len_i = 4'd0; src_a_i = 8'h00; src_b_i = 8'h00; dst_i = 8'h00;
        flagCarry = 1'b0; flagShift = 1'b0; pend_carry = 1'b0;
        prev_trig_c = 1'b0; prev_trig_s = 1'b0;
        reg_a = 8'h00; reg_b = 8'h00;
        r_err = 1'b0; r_zero = 1'b0; r_carry = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_carry", 32'(carry_out), 32'd0);
        checkOutput("rst_zero", 32'(result_zero), 32'd1);
        checkOutput("rst_addr", 32'(addr), 32'd0);
        checkOutput("rst_bars", 32'({assertBarM, assertBarE, assertBarS}), 32'h7);
        checkOutput("rst_strobes", 32'({memWrite, loadA, loadB, clearA, doSubtract,
                                        doCarryIn, triggerC, triggerS}), 32'h0);
        reset = 1'b0;

        // ADD 0x01FF + 0x0001 = 0x0200
        mem[8'h10] = 8'hFF; mem[8'h11] = 8'h01;
        mem[8'h20] = 8'h01; mem[8'h21] = 8'h00;
        applyStimulus(2'b00, 4'd2, 8'h10, 8'h20, 8'h30);
        checkOutput("add2_lat", 32'(lat), 32'd9);
        checkOutput("add2_lo", 32'(mem[8'h30]), 32'h00);
        checkOutput("add2_hi", 32'(mem[8'h31]), 32'h02);
        checkOutput("add2_cin_n", 32'(cin_log.size()), 32'd2);
        checkOutput("add2_cin0", 32'(cin_log[0]), 32'd0);
        checkOutput("add2_cin1", 32'(cin_log[1]), 32'd1);
        checkOutput("add2_carry", 32'(r_carry), 32'd0);
        checkOutput("add2_zero", 32'(r_zero), 32'd0);
        checkOutput("add2_err", 32'(r_err), 32'd0);
        @(negedge clk);
        checkOutput("add2_done_pulse", 32'(done), 32'd0);

        // ADD 0x80 + 0x80 = 0x00 carry 1
        mem[8'h40] = 8'h80; mem[8'h50] = 8'h80; mem[8'h60] = 8'hAA;
        applyStimulus(2'b00, 4'd1, 8'h40, 8'h50, 8'h60);
        checkOutput("add1_lat", 32'(lat), 32'd5);
        checkOutput("add1_res", 32'(mem[8'h60]), 32'h00);
        checkOutput("add1_carry", 32'(r_carry), 32'd1);
        checkOutput("add1_zero", 32'(r_zero), 32'd1);

        // SUB 0x05 - 0x07 = 0xFE
        mem[8'h70] = 8'h05; mem[8'h71] = 8'h07;
        applyStimulus(2'b01, 4'd1, 8'h70, 8'h71, 8'h72);
        checkOutput("sub1_lat", 32'(lat), 32'd5);
        checkOutput("sub1_res", 32'(mem[8'h72]), 32'hFE);
        checkOutput("sub1_carry", 32'(r_carry), 32'd0);

        applyStimulus(2'b01, 4'd2, 8'h70, 8'h71, 8'h74);
        checkOutput("sub2_lat", 32'(lat), 32'd1);
        checkOutput("sub2_err", 32'(r_err), 32'd1);
        checkOutput("sub2_writes", 32'(write_log.size()), 32'd0);

        // SHR 0x0301 -> 0x0180, carry 1
        mem[8'h80] = 8'h01; mem[8'h81] = 8'h03;
        applyStimulus(2'b10, 4'd2, 8'h80, 8'h00, 8'h90);
        checkOutput("shr_lat", 32'(lat), 32'd9);
        checkOutput("shr_reads_n", 32'(read_log.size()), 32'd2);
        checkOutput("shr_read0", 32'(read_log[0]), 32'h81);
        checkOutput("shr_read1", 32'(read_log[1]), 32'h80);
        checkOutput("shr_write0", 32'(write_log[0]), 32'h91);
        checkOutput("shr_lo", 32'(mem[8'h90]), 32'h80);
        checkOutput("shr_hi", 32'(mem[8'h91]), 32'h01);
        checkOutput("shr_carry", 32'(r_carry), 32'd1);
        checkOutput("shr_zero", 32'(r_zero), 32'd0);

        // Address wrap: 0x0302 + 0x0101 = 0x0403 with src_a at 0xFF
        mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03;
        mem[8'hA0] = 8'h01; mem[8'hA1] = 8'h01;
        applyStimulus(2'b00, 4'd2, 8'hFF, 8'hA0, 8'hB0);
        checkOutput("wrap_reads_n", 32'(read_log.size()), 32'd4);
        checkOutput("wrap_read2", 32'(read_log[2]), 32'h00);
        checkOutput("wrap_lo", 32'(mem[8'hB0]), 32'h03);
        checkOutput("wrap_hi", 32'(mem[8'hB1]), 32'h04);

        applyStimulus(2'b11, 4'd1, 8'h10, 8'h20, 8'hC0);
        checkOutput("op11_lat", 32'(lat), 32'd1);
        checkOutput("op11_err", 32'(r_err), 32'd1);
        applyStimulus(2'b00, 4'd0, 8'h10, 8'h20, 8'hC0);
        checkOutput("len0_lat", 32'(lat), 32'd1);
        checkOutput("len0_err", 32'(r_err), 32'd1);
        applyStimulus(2'b00, 4'd9, 8'h10, 8'h20, 8'hC0);
        checkOutput("len9_err", 32'(r_err), 32'd1);
        checkOutput("len9_writes", 32'(write_log.size()), 32'd0);

        // Reset during EXEC, then a normal command.
        mem[8'hC0] = 8'h11; mem[8'hC8] = 8'h22;
        @(negedge clk);
        op_i = 2'b00; len_i = 4'd1; src_a_i = 8'hC0; src_b_i = 8'hC8; dst_i = 8'hD0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (!assertBarE) begin
                lat = k;
                break;
            end
        end
        checkOutput("rstx_exec_cycle", 32'(lat), 32'd3);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstx_busy", 32'(busy), 32'd0);
        checkOutput("rstx_memwrite", 32'(memWrite), 32'd0);
        checkOutput("rstx_bar_e", 32'(assertBarE), 32'd1);
        checkOutput("rstx_trigger", 32'({triggerC, triggerS}), 32'd0);
        reset = 1'b0;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) lat++;
        end
        checkOutput("rstx_no_done", 32'(lat), 32'd0);
        applyStimulus(2'b00, 4'd1, 8'hC0, 8'hC8, 8'hD0);
        checkOutput("rstx_next_lat", 32'(lat), 32'd5);
        checkOutput("rstx_next_res", 32'(mem[8'hD0]), 32'h33);
        checkOutput("rstx_next_carry", 32'(r_carry), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
